// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider: FSM encoding and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  function automatic int cnt_width(input int b);
    return $clog2(b);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_sub.sv
// Ripple-borrow n-bit subtractor: diff = a - b - bin, bout set on underflow.
module FullSubstracter_nBits #(
  parameter int bits = 33
) (
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  input  logic            bin,
  output logic [bits-1:0] diff,
  output logic            bout
);

  logic [bits:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < bits; i++) begin : g_stage
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign bout = borrow[bits];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Divide by zero short-circuits to DONE with quotient all ones and remainder = dividend.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int bits = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [bits-1:0] dividend,
  input  logic [bits-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] quotient,
  output logic [bits-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = cnt_width(bits);

  div_state_t      state, state_nx;
  logic [bits-1:0] q_reg, r_reg, d_reg;
  logic [CW-1:0]   cnt;
  logic            dz_reg;
  logic [bits:0]   shifted, trial;
  logic            bout;
  logic            keep;

  assign shifted = {r_reg, q_reg[bits-1]};

  FullSubstracter_nBits #(.bits(bits + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, d_reg}),
    .bin  (1'b0),
    .diff (trial),
    .bout (bout)
  );

  // R < divisor holds every step, so a non-borrowing trial always has a clear MSB.
  assign keep = ~bout & ~trial[bits];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg  <= '0;
      r_reg  <= '0;
      d_reg  <= '0;
      cnt    <= '0;
      dz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              q_reg  <= '1;
              r_reg  <= dividend;
              dz_reg <= 1'b1;
            end else begin
              d_reg  <= divisor;
              q_reg  <= dividend;
              r_reg  <= '0;
              cnt    <= CW'(bits - 1);
              dz_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          if (keep) begin
            r_reg <= trial[bits-1:0];
            q_reg <= {q_reg[bits-2:0], 1'b1};
          end else begin
            r_reg <= shifted[bits-1:0];
            q_reg <= {q_reg[bits-2:0], 1'b0};
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider at bits=32 and bits=8.
module tb_seq_restoring_divider;

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  logic        clk, rst;
  logic        start, busy, done, dz;
  logic [31:0] dvd, dvs, q, r;
  logic        start8, busy8, done8, dz8;
  logic [7:0]  dvd8, dvs8, q8, r8;

  int checks = 0;
  int failures = 0;

  seq_restoring_divider #(.bits(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .dividend(dvd), .divisor(dvs),
    .busy(busy), .done(done), .quotient(q), .remainder(r), .div_by_zero(dz)
  );

  seq_restoring_divider #(.bits(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run32(input vec_t v, input string tag);
    int lat, bcnt;
    bit got;
    lat = 0; bcnt = 0; got = 0;
    @(negedge clk);
    dvd = v.dividend; dvs = v.divisor; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) got = 1;
    end
    if (!got) begin
      chk({tag, " timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, " quotient"}, q, v.exp_q);
      chk({tag, " remainder"}, r, v.exp_r);
      chk({tag, " div_by_zero"}, dz, v.exp_dz);
      chk({tag, " latency"}, lat, v.exp_lat);
      chk({tag, " busy_cycles"}, bcnt, v.exp_lat);
      @(negedge clk);
      chk({tag, " done_pulse"}, {busy, done}, 2'b00);
      chk({tag, " held_q"}, q, v.exp_q);
    end
  endtask

  task automatic run8(input vec_t v, input string tag);
    int lat;
    bit got;
    lat = 0; got = 0;
    @(negedge clk);
    dvd8 = v.dividend[7:0]; dvs8 = v.divisor[7:0]; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (done8) got = 1;
    end
    if (!got) begin
      chk({tag, " timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, " quotient"}, q8, v.exp_q[7:0]);
      chk({tag, " remainder"}, r8, v.exp_r[7:0]);
      chk({tag, " div_by_zero"}, dz8, v.exp_dz);
      chk({tag, " latency"}, lat, v.exp_lat);
    end
  endtask

  vec_t v32[7];
  vec_t v8[3];

  initial begin
    int dcnt;
    logic [31:0] cq, cr;

    v32[0] = '{32'd100,        32'd7,    32'd14,         32'd2, 1'b0, 33};
    v32[1] = '{32'hFFFF_FFFF,  32'd1,    32'hFFFF_FFFF,  32'd0, 1'b0, 33};
    v32[2] = '{32'd3,          32'd10,   32'd0,          32'd3, 1'b0, 33};
    v32[3] = '{32'd5,          32'd0,    32'hFFFF_FFFF,  32'd5, 1'b1, 1};
    v32[4] = '{32'd9,          32'd3,    32'd3,          32'd0, 1'b0, 33};
    v32[5] = '{32'd1000,       32'd1000, 32'd1,          32'd0, 1'b0, 33};
    v32[6] = '{32'd0,          32'd5,    32'd0,          32'd0, 1'b0, 33};
    v8[0]  = '{32'd200,        32'd13,   32'd15,         32'd5, 1'b0, 9};
    v8[1]  = '{32'd255,        32'd255,  32'd1,          32'd0, 1'b0, 9};
    v8[2]  = '{32'd7,          32'd0,    32'd255,        32'd7, 1'b1, 1};

    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    dvd = '0; dvs = '0; dvd8 = '0; dvs8 = '0;
    #2;
    chk("reset32", {busy, done, q, r, dz}, 67'd0);
    chk("reset8", {busy8, done8, q8, r8, dz8}, 19'd0);
    #10 rst = 1'b0;

    for (int i = 0; i < 7; i++) run32(v32[i], $sformatf("v32_%0d", i));
    for (int i = 0; i < 3; i++) run8(v8[i], $sformatf("v8_%0d", i));

    // second start mid-run must be ignored
    dcnt = 0; cq = '0; cr = '0;
    @(negedge clk);
    dvd = 32'd100; dvs = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 10) begin
        dvd = 32'd50; dvs = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcnt++;
        cq = q; cr = r;
      end
    end
    chk("ignore_start done_count", dcnt, 1);
    chk("ignore_start quotient", cq, 32'd14);
    chk("ignore_start remainder", cr, 32'd2);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    dvd = 32'd100; dvs = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_reset busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset outputs", {busy, done, q, r, dz}, 67'd0);
    #1 rst = 1'b0;
    begin
      vec_t vr;
      vr = '{32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33};
      run32(vr, "after_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
